// File: rtl/rv32_instruction_buffer.sv
// rv32_instruction_buffer: DEPTH-entry {pc, instruction} FIFO between fetch and decode.
// The head entry is split into RV32 fields. The canonical NOP and pc 0 are shown
// whenever no valid entry is available or a flush is in progress.
// Optional macro RV32_IBUF_BYPASS_EN: on an empty buffer, the incoming fetch word is
// presented to decode in the same cycle, and it skips the FIFO if decode takes it.
module rv32_instruction_buffer #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic                     flush_in,
    input  logic                     instr_valid_in,
    input  logic [31:0]              instr_in,
    input  logic [31:0]              pc_in,
    output logic                     instr_ready_out,
    output logic                     dec_valid_out,
    input  logic                     dec_ready_in,
    output logic [31:0]              pc_out,
    output logic [6:0]               opcode_out,
    output logic [2:0]               funct3_out,
    output logic [6:0]               funct7_out,
    output logic [4:0]               rs1addr_out,
    output logic [4:0]               rs2addr_out,
    output logic [4:0]               rdaddr_out,
    output logic [11:0]              csr_addr_out,
    output logic [24:0]              instr_31_7_out,
    output logic [$clog2(DEPTH):0]   count_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      instr_mem [DEPTH];
    logic [31:0]      pc_mem    [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;

    logic             buf_valid;
    logic             bypass_active;
    logic             bypass_take;
    logic             push;
    logic             pop;
    logic             wr_en;
    logic             rd_en;
    logic [31:0]      head_instr;
    logic [31:0]      head_pc;
    logic [31:0]      dec_instr;

    // Handshake qualifiers; flush blocks both sides this cycle
    assign buf_valid       = (count_q != '0) && !flush_in;
    assign instr_ready_out = (count_q != CNT_W'(DEPTH)) && !flush_in;

`ifdef RV32_IBUF_BYPASS_EN
    // Empty buffer forwards the fetch word straight to decode
    assign bypass_active = (count_q == '0) && !flush_in && instr_valid_in;
    assign bypass_take   = bypass_active && dec_ready_in;
`else
    assign bypass_active = 1'b0;
    assign bypass_take   = 1'b0;
`endif

    assign dec_valid_out = buf_valid || bypass_active;
    assign push          = instr_valid_in && instr_ready_out;
    assign pop           = dec_valid_out && dec_ready_in;
    // A bypassed word consumed by decode never touches the FIFO
    assign wr_en         = push && !bypass_take;
    assign rd_en         = pop && !bypass_take;

    // Select the presented word: head entry, bypass word, or NOP
    always_comb begin
        head_instr = instr_mem[rd_ptr];
        head_pc    = pc_mem[rd_ptr];
        if (bypass_active) begin
            head_instr = instr_in;
            head_pc    = pc_in;
        end
        dec_instr = NOP_INSTR;
        pc_out    = '0;
        if (dec_valid_out) begin
            dec_instr = head_instr;
            pc_out    = head_pc;
        end
    end

    // RV32 field split of the presented word
    assign opcode_out     = dec_instr[6:0];
    assign rdaddr_out     = dec_instr[11:7];
    assign funct3_out     = dec_instr[14:12];
    assign rs1addr_out    = dec_instr[19:15];
    assign rs2addr_out    = dec_instr[24:20];
    assign funct7_out     = dec_instr[31:25];
    assign csr_addr_out   = dec_instr[31:20];
    assign instr_31_7_out = dec_instr[31:7];
    assign count_out      = count_q;

    // Storage write at the tail; contents are not cleared by reset or flush
    always_ff @(posedge clk_in) begin
        if (wr_en && !reset_in) begin
            instr_mem[wr_ptr] <= instr_in;
            pc_mem[wr_ptr]    <= pc_in;
        end
    end

    // Pointers and occupancy; reset beats flush, flush beats push/pop
    always_ff @(posedge clk_in) begin
        if (reset_in || flush_in) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_instruction_buffer.sv
// Directed bench for rv32_instruction_buffer (DEPTH=4).
module tb_rv32_instruction_buffer;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        flush_in;
    logic        instr_valid_in;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic        instr_ready_out;
    logic        dec_valid_out;
    logic        dec_ready_in;
    logic [31:0] pc_out;
    logic [6:0]  opcode_out;
    logic [2:0]  funct3_out;
    logic [6:0]  funct7_out;
    logic [4:0]  rs1addr_out;
    logic [4:0]  rs2addr_out;
    logic [4:0]  rdaddr_out;
    logic [11:0] csr_addr_out;
    logic [24:0] instr_31_7_out;
    logic [2:0]  count_out;

    int n_cmp  = 0;
    int n_fail = 0;

    rv32_instruction_buffer #(.DEPTH(4), .NOP_INSTR(32'h00000013)) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .flush_in        (flush_in),
        .instr_valid_in  (instr_valid_in),
        .instr_in        (instr_in),
        .pc_in           (pc_in),
        .instr_ready_out (instr_ready_out),
        .dec_valid_out   (dec_valid_out),
        .dec_ready_in    (dec_ready_in),
        .pc_out          (pc_out),
        .opcode_out      (opcode_out),
        .funct3_out      (funct3_out),
        .funct7_out      (funct7_out),
        .rs1addr_out     (rs1addr_out),
        .rs2addr_out     (rs2addr_out),
        .rdaddr_out      (rdaddr_out),
        .csr_addr_out    (csr_addr_out),
        .instr_31_7_out  (instr_31_7_out),
        .count_out       (count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        dready;
        logic        chk;
        logic        e_ready;
        logic        e_dvalid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [2:0]  e_count;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic flush, input logic valid,
                                input logic [31:0] instr, input logic [31:0] pc,
                                input logic dready, input logic chk, input logic e_ready,
                                input logic e_dvalid, input logic [31:0] e_instr,
                                input logic [31:0] e_pc, input logic [2:0] e_count);
        vec_t v;
        v.rst = rst; v.flush = flush; v.valid = valid; v.instr = instr; v.pc = pc;
        v.dready = dready; v.chk = chk; v.e_ready = e_ready; v.e_dvalid = e_dvalid;
        v.e_instr = e_instr; v.e_pc = e_pc; v.e_count = e_count;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Compare every output against the expected presented word and status
    task automatic check_out(input string tag, input logic e_ready, input logic e_dvalid,
                             input logic [31:0] e_instr, input logic [31:0] e_pc,
                             input logic [2:0] e_count);
        cmp({tag, ".ready"},  32'(instr_ready_out), 32'(e_ready));
        cmp({tag, ".dvalid"}, 32'(dec_valid_out),   32'(e_dvalid));
        cmp({tag, ".pc"},     pc_out,               e_pc);
        cmp({tag, ".opcode"}, 32'(opcode_out),      32'(e_instr[6:0]));
        cmp({tag, ".rd"},     32'(rdaddr_out),      32'(e_instr[11:7]));
        cmp({tag, ".funct3"}, 32'(funct3_out),      32'(e_instr[14:12]));
        cmp({tag, ".rs1"},    32'(rs1addr_out),     32'(e_instr[19:15]));
        cmp({tag, ".rs2"},    32'(rs2addr_out),     32'(e_instr[24:20]));
        cmp({tag, ".funct7"}, 32'(funct7_out),      32'(e_instr[31:25]));
        cmp({tag, ".csr"},    32'(csr_addr_out),    32'(e_instr[31:20]));
        cmp({tag, ".i31_7"},  32'(instr_31_7_out),  32'(e_instr[31:7]));
        cmp({tag, ".count"},  32'(count_out),       32'(e_count));
    endtask

    task automatic drive(input logic rst, input logic flush, input logic valid,
                         input logic [31:0] instr, input logic [31:0] pc, input logic dready);
        @(negedge clk_in);
        reset_in       = rst;
        flush_in       = flush;
        instr_valid_in = valid;
        instr_in       = instr;
        pc_in          = pc;
        dec_ready_in   = dready;
        #1;
    endtask

    function automatic logic [31:0] w(input int i);
        return NOP | (32'(i) << 7);
    endfunction

    vec_t vecs[23];

    initial begin
        reset_in = 1'b1; flush_in = 1'b0; instr_valid_in = 1'b0;
        instr_in = '0; pc_in = '0; dec_ready_in = 1'b0;

        //             rst  fl  vld  instr          pc      dr  chk rdy dv  e_instr        e_pc    cnt
        vecs[0]  = mk(1, 0, 0, 32'h0,        32'h0,   0, 0, 0, 0, NOP,          32'h0,   3'd0);
        vecs[1]  = mk(0, 0, 0, 32'h0,        32'h0,   0, 1, 1, 0, NOP,          32'h0,   3'd0);
        vecs[2]  = mk(0, 0, 1, 32'h00500093, 32'h100, 0, 1, 1, 0, NOP,          32'h0,   3'd0);
        vecs[3]  = mk(0, 0, 0, 32'h0,        32'h0,   0, 1, 1, 1, 32'h00500093, 32'h100, 3'd1);
        vecs[4]  = mk(0, 0, 1, w(2),         32'h104, 0, 1, 1, 1, 32'h00500093, 32'h100, 3'd1);
        vecs[5]  = mk(0, 0, 1, w(3),         32'h108, 0, 1, 1, 1, 32'h00500093, 32'h100, 3'd2);
        vecs[6]  = mk(0, 0, 1, w(4),         32'h10c, 0, 1, 1, 1, 32'h00500093, 32'h100, 3'd3);
        vecs[7]  = mk(0, 0, 1, w(5),         32'h110, 0, 1, 0, 1, 32'h00500093, 32'h100, 3'd4);
        vecs[8]  = mk(0, 0, 1, w(5),         32'h110, 1, 1, 0, 1, 32'h00500093, 32'h100, 3'd4);
        vecs[9]  = mk(0, 0, 1, w(5),         32'h110, 0, 1, 1, 1, w(2),         32'h104, 3'd3);
        vecs[10] = mk(0, 0, 0, 32'h0,        32'h0,   1, 1, 0, 1, w(2),         32'h104, 3'd4);
        vecs[11] = mk(0, 0, 0, 32'h0,        32'h0,   1, 1, 1, 1, w(3),         32'h108, 3'd3);
        vecs[12] = mk(0, 0, 0, 32'h0,        32'h0,   1, 1, 1, 1, w(4),         32'h10c, 3'd2);
        vecs[13] = mk(0, 0, 0, 32'h0,        32'h0,   1, 1, 1, 1, w(5),         32'h110, 3'd1);
        vecs[14] = mk(0, 0, 0, 32'h0,        32'h0,   0, 1, 1, 0, NOP,          32'h0,   3'd0);
        vecs[15] = mk(0, 0, 1, w(6),         32'h200, 0, 1, 1, 0, NOP,          32'h0,   3'd0);
        vecs[16] = mk(0, 0, 1, w(7),         32'h204, 0, 1, 1, 1, w(6),         32'h200, 3'd1);
        vecs[17] = mk(0, 0, 1, w(8),         32'h208, 0, 1, 1, 1, w(6),         32'h200, 3'd2);
        vecs[18] = mk(0, 1, 1, w(9),         32'h20c, 1, 1, 0, 0, NOP,          32'h0,   3'd3);
        vecs[19] = mk(0, 0, 0, 32'h0,        32'h0,   0, 1, 1, 0, NOP,          32'h0,   3'd0);
        vecs[20] = mk(0, 0, 1, w(10),        32'h300, 0, 1, 1, 0, NOP,          32'h0,   3'd0);
        vecs[21] = mk(1, 0, 0, 32'h0,        32'h0,   0, 1, 1, 1, w(10),        32'h300, 3'd1);
        vecs[22] = mk(0, 0, 0, 32'h0,        32'h0,   0, 1, 1, 0, NOP,          32'h0,   3'd0);

        for (int i = 0; i < 23; i++) begin
            vec_t v;
            v = vecs[i];
`ifdef RV32_IBUF_BYPASS_EN
            if (v.valid && !v.flush && v.e_count == 3'd0) begin
                v.e_dvalid = 1'b1;
                v.e_instr  = v.instr;
                v.e_pc     = v.pc;
            end
`endif
            drive(v.rst, v.flush, v.valid, v.instr, v.pc, v.dready);
            if (v.chk) begin
                check_out($sformatf("vec%0d", i), v.e_ready, v.e_dvalid, v.e_instr, v.e_pc, v.e_count);
            end
        end

        // Streaming: one push and one pop per cycle keeps occupancy at 1
        drive(0, 0, 1, w(0), 32'h400, 0);
        for (int i = 1; i <= 10; i++) begin
            drive(0, 0, (i < 10), w(i), 32'h400 + 32'(4 * i), 1);
            check_out($sformatf("stream%0d", i), 1'b1, 1'b1, w(i - 1),
                      32'h400 + 32'(4 * (i - 1)), 3'd1);
        end
        drive(0, 0, 0, 32'h0, 32'h0, 0);
        check_out("stream_end", 1'b1, 1'b0, NOP, 32'h0, 3'd0);

        // Flush with reset together: reset wins, state empty afterwards
        drive(0, 0, 1, w(11), 32'h500, 0);
        drive(1, 1, 1, w(12), 32'h504, 0);
        check_out("rstflush", 1'b0, 1'b0, NOP, 32'h0, 3'd1);
        drive(0, 0, 0, 32'h0, 32'h0, 0);
        check_out("rstflush_after", 1'b1, 1'b0, NOP, 32'h0, 3'd0);

`ifdef RV32_IBUF_BYPASS_EN
        // Same-cycle bypass consumed by decode, then bypass that falls into the FIFO
        drive(0, 0, 1, 32'h00000073, 32'h600, 1);
        check_out("byp_take", 1'b1, 1'b1, 32'h00000073, 32'h600, 3'd0);
        drive(0, 0, 0, 32'h0, 32'h0, 0);
        check_out("byp_take_after", 1'b1, 1'b0, NOP, 32'h0, 3'd0);
        drive(0, 0, 1, 32'h00100073, 32'h604, 0);
        check_out("byp_hold", 1'b1, 1'b1, 32'h00100073, 32'h604, 3'd0);
        drive(0, 0, 0, 32'h0, 32'h0, 0);
        check_out("byp_hold_after", 1'b1, 1'b1, 32'h00100073, 32'h604, 3'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32_instruction_buffer.md
Name: rv32_instruction_buffer

Overview:
- Parametrised instruction buffer between fetch and decode.
- Holds a DEPTH-entry FIFO of {pc, instruction} pairs with valid/ready handshakes on both sides.
- Decodes the head entry into RV32 instruction fields.
- Substitutes the canonical NOP (addi x0,x0,0 = 32'h00000013) whenever the buffer is empty or being flushed, and flush discards all buffered entries.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- NOP_INSTR, 32'h00000013, instruction word presented when no valid entry is available.

Ports:
- clk_in  input  1  clock, all state on rising edge
- reset_in  input  1  synchronous, active-high reset
- flush_in  input  1  discard all entries; outputs forced to NOP this cycle
- instr_valid_in  input  1  fetch presents a valid instruction
- instr_in  input  32  fetched instruction word
- pc_in  input  32  PC of instr_in
- instr_ready_out  output  1  buffer can accept (count < DEPTH and not flush_in)
- dec_valid_out  output  1  head entry valid for decode
- dec_ready_in  input  1  decode consumes head this cycle
- pc_out  output  32  PC of head entry; 0 when no valid entry
- opcode_out  output  7  instr[6:0]
- funct3_out  output  3  instr[14:12]
- funct7_out  output  7  instr[31:25]
- rs1addr_out  output  5  instr[19:15]
- rs2addr_out  output  5  instr[24:20]
- rdaddr_out  output  5  instr[11:7]
- csr_addr_out  output  12  instr[31:20]
- instr_31_7_out  output  25  instr[31:7]
- count_out  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (reset_in=1 at a rising edge):
  - Read/write pointers and count go to 0.
  - Next cycle: dec_valid_out=0, instr_ready_out=1, pc_out=0, count_out=0, field outputs decode NOP_INSTR.
- Reset mid-operation drops all entries; storage RAM contents need not be cleared.
- Push: instr_valid_in && instr_ready_out. The entry is written at the tail and the write pointer increments modulo DEPTH (wraps DEPTH-1 -> 0).
- Pop: dec_valid_out && dec_ready_in. The read pointer increments modulo DEPTH.
- Simultaneous push and pop:
  - count unchanged.
  - Allowed when the buffer is full only if instr_ready_out permits; instr_ready_out is based on count < DEPTH, so no push occurs at full even with a pop that cycle.
- Latency: an entry pushed at edge N is visible at the head from cycle N+1 (registered path).
- dec_valid_out = (count != 0) && !flush_in.
- Field outputs decode the head instruction when dec_valid_out=1; otherwise they decode NOP_INSTR and pc_out=0.
- Flush (flush_in=1):
  - Combinationally forces NOP/invalid outputs and instr_ready_out=0.
  - At the edge, pointers and count clear to 0.
  - Any push or pop requested that cycle is ignored.
  - Flush has priority over push/pop; reset has priority over flush.
- Full (count==DEPTH): instr_ready_out=0; instr_valid_in ignored.
- Empty (count==0): pop impossible; dec_ready_in ignored.
- Holding: when dec_valid_out=1 and dec_ready_in=0, outputs stay stable until popped or flushed.

Optional Feature:
- Macro RV32_IBUF_BYPASS_EN.
- Defined:
  - When count==0 and flush_in=0, an incoming instr_valid_in presents instr_in/pc_in on the outputs in the same cycle, with dec_valid_out=instr_valid_in.
  - If dec_ready_in=1 that cycle, the word is consumed and not written (count stays 0). Otherwise it is written normally.
- Not defined: strict one-cycle registered latency as above; no combinational path from instr_in to decode outputs.

Test Plan:
- Reset, then idle -> dec_valid_out=0, opcode_out=7'h13, rdaddr_out=0, instr_ready_out=1, count_out=0.
- Push 32'h00500093 @ pc 32'h100, dec_ready_in=0 -> next cycle dec_valid_out=1, opcode_out=7'h13, rdaddr_out=1, rs1addr_out=0, csr_addr_out=12'h005, pc_out=32'h100, count_out=1.
- Push 4 words with dec_ready_in=0 (DEPTH=4) -> count_out=4, instr_ready_out=0; 5th word held off; pop one -> instr_ready_out=1 next cycle; FIFO order preserved across pointer wrap.
- Buffer holding 3 entries, assert flush_in with instr_valid_in=1 for one cycle -> same cycle dec_valid_out=0 and outputs=NOP; next cycle count_out=0 and the flushed-cycle word is absent.
- Continuous push and pop each cycle for 10 words (0x...13 + i<<7) -> count_out constant at 1, rdaddr_out sequence 0..9 each one cycle after push.
- With RV32_IBUF_BYPASS_EN, empty buffer, push 32'h00000073 with dec_ready_in=1 -> same-cycle dec_valid_out=1, opcode_out=7'h73, count_out stays 0.
